regfile_writeback_arbiter: RTL and testbench

- Write-back stage directly upstream of the 16x16 register file.
- Accepts results from two producers, the ALU and the load/store unit, over valid/ready handshakes.
- Arbitrates between them and buffers accepted results in a small in-order FIFO.
- Drives the register file's single write port: write enable, 4-bit address, 16-bit data.
- Reports pending-write hazards so the issue stage can stall reads of registers that still have a write in flight.

---
 rtl/regfile_writeback_arbiter_if.sv | 41 ++++
 rtl/regfile_writeback_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_writeback_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_arbiter_if.sv
// Handshake and write-port bundle for the write-back arbiter.
// master: producers / register file / issue side; slave: arbiter.
interface regfile_writeback_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
);
   logic                         alu_valid;
   logic                         alu_ready;
   logic [ADDR_W-1:0]            alu_addr;
   logic [DATA_W-1:0]            alu_data;
   logic                         mem_valid;
   logic                         mem_ready;
   logic [ADDR_W-1:0]            mem_addr;
   logic [DATA_W-1:0]            mem_data;
   logic                         rf_hold;
   logic                         rf_we;
   logic [ADDR_W-1:0]            rf_waddr;
   logic [DATA_W-1:0]            rf_wdata;
   logic [ADDR_W-1:0]            query_addr;
   logic                         query_hit;
   logic [$clog2(DEPTH+1)-1:0]   pending_cnt;

   modport master (
      output alu_valid, alu_addr, alu_data,
      output mem_valid, mem_addr, mem_data,
      output rf_hold, query_addr,
      input  alu_ready, mem_ready,
      input  rf_we, rf_waddr, rf_wdata,
      input  query_hit, pending_cnt
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data,
      input  mem_valid, mem_addr, mem_data,
      input  rf_hold, query_addr,
      output alu_ready, mem_ready,
      output rf_we, rf_waddr, rf_wdata,
      output query_hit, pending_cnt
   );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Write-back arbiter: ALU/load results into an in-order FIFO feeding the RF.
// Optional WB_ARB_ROUND_ROBIN_EN alternates priority between the producers.
module regfile_writeback_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic clk,
   input  logic reset,
   regfile_writeback_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;

   logic              w_space;
   logic              w_gnt_mem;
   logic              w_gnt_alu;
   logic              w_push;
   logic              w_pop;
   logic              w_hit;
   logic [ADDR_W-1:0] w_in_addr;
   logic [DATA_W-1:0] w_in_data;

   // No full pass-through: a pop in the same cycle does not open a slot.
   assign w_space = !reset && (r_count < FULL);

`ifdef WB_ARB_ROUND_ROBIN_EN
   logic r_prio;

   always_comb begin
      w_gnt_mem = 1'b0;
      w_gnt_alu = 1'b0;
      if (w_space) begin
         w_gnt_mem = bus.mem_valid && (!bus.alu_valid || !r_prio);
         w_gnt_alu = bus.alu_valid && (!bus.mem_valid || r_prio);
      end
   end

   // Flip only on contended grants, toward the producer that lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prio <= 1'b0;
      end else if (w_gnt_mem && bus.alu_valid) begin
         r_prio <= 1'b1;
      end else if (w_gnt_alu && bus.mem_valid) begin
         r_prio <= 1'b0;
      end
   end
`else
   always_comb begin
      w_gnt_mem = 1'b0;
      w_gnt_alu = 1'b0;
      if (w_space) begin
         w_gnt_mem = bus.mem_valid;
         w_gnt_alu = bus.alu_valid && !bus.mem_valid;
      end
   end
`endif

   assign w_push    = w_gnt_mem || w_gnt_alu;
   assign w_pop     = (r_count != '0) && !bus.rf_hold;
   assign w_in_addr = w_gnt_mem ? bus.mem_addr : bus.alu_addr;
   assign w_in_data = w_gnt_mem ? bus.mem_data : bus.alu_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
      end else if (w_push) begin
         r_addr[r_wr_ptr] <= w_in_addr;
         r_data[r_wr_ptr] <= w_in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Occupied slots are those within r_count of the read pointer.
   always_comb begin
      logic [PTR_W-1:0] v_off;
      w_hit = 1'b0;
      v_off = '0;
      for (int i = 0; i < DEPTH; i++) begin
         v_off = PTR_W'(i) - r_rd_ptr;
         if ((CNT_W'(v_off) < r_count) &&
             (r_addr[i] == bus.query_addr)) begin
            w_hit = 1'b1;
         end
      end
   end

   assign bus.alu_ready   = w_gnt_alu;
   assign bus.mem_ready   = w_gnt_mem;
   assign bus.rf_we       = w_pop;
   assign bus.rf_waddr    = r_addr[r_rd_ptr];
   assign bus.rf_wdata    = r_data[r_rd_ptr];
   assign bus.query_hit   = w_hit;
   assign bus.pending_cnt = r_count;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter with a queue-based model.
module tb_regfile_writeback_arbiter;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 4;

   logic clk;
   logic reset;

   regfile_writeback_arbiter_if #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
   ) bus ();

   regfile_writeback_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_chk;
   int n_err;

   logic [ADDR_W+DATA_W-1:0] q[$];
   bit m_prio;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void exp_grant(output bit gm, output bit ga);
      bit room;
      room = !reset && (q.size() < DEPTH);
      gm = 1'b0;
      ga = 1'b0;
      if (room) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
         if (bus.mem_valid && bus.alu_valid) begin
            gm = !m_prio;
            ga = m_prio;
         end else begin
            gm = bus.mem_valid;
            ga = bus.alu_valid;
         end
`else
         gm = bus.mem_valid;
         ga = bus.alu_valid && !bus.mem_valid;
`endif
      end
   endfunction

   always @(posedge clk or posedge reset) begin : model
      bit gm, ga;
      if (reset) begin
         q.delete();
         m_prio = 1'b0;
      end else begin
         exp_grant(gm, ga);
         if (q.size() > 0 && !bus.rf_hold) void'(q.pop_front());
         if (gm) q.push_back({bus.mem_addr, bus.mem_data});
         else if (ga) q.push_back({bus.alu_addr, bus.alu_data});
         if (bus.mem_valid && bus.alu_valid && (gm || ga)) m_prio = ga ? 1'b0 : 1'b1;
      end
   end

   always @(negedge clk) begin : compare
      bit gm, ga, hit;
      exp_grant(gm, ga);
      hit = 1'b0;
      foreach (q[i]) if (q[i][ADDR_W+DATA_W-1:DATA_W] == bus.query_addr) hit = 1'b1;
      chk("m_rf_we", 32'(bus.rf_we), 32'(!reset && q.size() > 0 && !bus.rf_hold));
      chk("m_pending", 32'(bus.pending_cnt), 32'(q.size()));
      chk("m_mem_ready", 32'(bus.mem_ready), 32'(gm));
      chk("m_alu_ready", 32'(bus.alu_ready), 32'(ga));
      chk("m_query_hit", 32'(bus.query_hit), 32'(hit));
      if (q.size() > 0) begin
         chk("m_waddr", 32'(bus.rf_waddr), 32'(q[0][ADDR_W+DATA_W-1:DATA_W]));
         chk("m_wdata", 32'(bus.rf_wdata), 32'(q[0][DATA_W-1:0]));
      end else if (reset) begin
         chk("m_rst_waddr", 32'(bus.rf_waddr), 32'h0);
         chk("m_rst_wdata", 32'(bus.rf_wdata), 32'h0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      reset = 1'b1;
      bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
      bus.mem_valid = 0; bus.mem_addr = 0; bus.mem_data = 0;
      bus.rf_hold = 0; bus.query_addr = 0;
      repeat (2) neg();
      chk("rst_we", 32'(bus.rf_we), 0);
      chk("rst_waddr", 32'(bus.rf_waddr), 0);
      chk("rst_wdata", 32'(bus.rf_wdata), 0);
      chk("rst_alu_ready", 32'(bus.alu_ready), 0);
      chk("rst_mem_ready", 32'(bus.mem_ready), 0);
      chk("rst_pending", 32'(bus.pending_cnt), 0);
      step();
      reset = 1'b0;
      step();

      // Single ALU write, 1-cycle latency
      bus.alu_valid = 1; bus.alu_addr = 3; bus.alu_data = 16'hBEEF;
      neg();
      chk("t1_alu_ready", 32'(bus.alu_ready), 1);
      step();
      bus.alu_valid = 0;
      neg();
      chk("t1_we", 32'(bus.rf_we), 1);
      chk("t1_waddr", 32'(bus.rf_waddr), 3);
      chk("t1_wdata", 32'(bus.rf_wdata), 32'hBEEF);
      step();
      neg();
      chk("t1_pending0", 32'(bus.pending_cnt), 0);

      // Fill under hold, then drain in order
      step();
      bus.rf_hold = 1;
      for (int i = 1; i <= 4; i++) begin
         bus.alu_valid = 1; bus.alu_addr = 4'(i); bus.alu_data = 16'(16'h1000 + i);
         neg();
         step();
      end
      bus.alu_addr = 5; bus.alu_data = 16'h1005;
      neg();
      chk("t2_full_cnt", 32'(bus.pending_cnt), 4);
      chk("t2_full_ready", 32'(bus.alu_ready), 0);
      step();
      bus.rf_hold = 0;
      neg();
      chk("t4_full_pop_ready", 32'(bus.alu_ready), 0);
      chk("t4_full_pop_we", 32'(bus.rf_we), 1);
      chk("t2_order1", 32'(bus.rf_waddr), 1);
      step();
      neg();
      chk("t4_cnt3", 32'(bus.pending_cnt), 3);
      chk("t4_ready_back", 32'(bus.alu_ready), 1);
      chk("t2_order2", 32'(bus.rf_waddr), 2);
      step();
      bus.alu_valid = 0;
      neg();
      chk("t2_order3", 32'(bus.rf_waddr), 3);
      chk("t4_cnt_hold", 32'(bus.pending_cnt), 3);
      step();
      neg();
      chk("t2_order4", 32'(bus.rf_waddr), 4);
      step();
      neg();
      chk("t4_tail5", 32'(bus.rf_waddr), 5);
      chk("t4_tail5_data", 32'(bus.rf_wdata), 32'h1005);
      step();
      neg();
      chk("t2_empty", 32'(bus.pending_cnt), 0);

      // Contention: both producers valid for 4 cycles
      step();
      bus.mem_valid = 1; bus.mem_addr = 5; bus.mem_data = 16'h5555;
      bus.alu_valid = 1; bus.alu_addr = 6; bus.alu_data = 16'h6666;
      for (int k = 0; k < 4; k++) begin
         neg();
`ifdef WB_ARB_ROUND_ROBIN_EN
         chk("t3_rr_mem", 32'(bus.mem_ready), 32'(k % 2 == 0));
         chk("t3_rr_alu", 32'(bus.alu_ready), 32'(k % 2 == 1));
`else
         chk("t3_fix_mem", 32'(bus.mem_ready), 1);
         chk("t3_fix_alu", 32'(bus.alu_ready), 0);
`endif
         step();
      end
      bus.mem_valid = 0; bus.alu_valid = 0;
      step();
      step();

      // Hazard query
      bus.alu_valid = 1; bus.alu_addr = 7; bus.alu_data = 16'h0777;
      bus.rf_hold = 1; bus.query_addr = 7;
      neg();
      chk("t5_hit_empty", 32'(bus.query_hit), 0);
      step();
      bus.alu_valid = 0;
      neg();
      chk("t5_hit7", 32'(bus.query_hit), 1);
      step();
      bus.query_addr = 8;
      neg();
      chk("t5_miss8", 32'(bus.query_hit), 0);
      step();
      bus.query_addr = 7; bus.rf_hold = 0;
      neg();
      chk("t5_hit_popping", 32'(bus.query_hit), 1);
      chk("t5_we", 32'(bus.rf_we), 1);
      step();
      neg();
      chk("t5_hit_drained", 32'(bus.query_hit), 0);

      // Reset mid-burst
      step();
      bus.rf_hold = 1; bus.query_addr = 10;
      for (int i = 10; i <= 12; i++) begin
         bus.alu_valid = 1; bus.alu_addr = 4'(i); bus.alu_data = 16'(16'hA000 + i);
         step();
      end
      bus.alu_valid = 0;
      neg();
      chk("t6_cnt3", 32'(bus.pending_cnt), 3);
      #2;
      bus.rf_hold = 0;
      #1;
      chk("t6_we_pre", 32'(bus.rf_we), 1);
      chk("t6_hit_pre", 32'(bus.query_hit), 1);
      reset = 1'b1;
      #1;
      chk("t6_we_async", 32'(bus.rf_we), 0);
      chk("t6_cnt_async", 32'(bus.pending_cnt), 0);
      chk("t6_hit_async", 32'(bus.query_hit), 0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         neg();
         chk("t6_no_stale", 32'(bus.rf_we), 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
